// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: FSM encoding, header
// field layout, default sizing and the engine ID map.
package cmd_pkg;

  localparam int NUM_ENGINES_DEF = 5;
  localparam int DATA_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int ERR_CNT_W_DEF   = 8;

  // Packet layout: byte 0 is the engine ID, byte 1 the payload length.
  localparam int HDR_ID_LSB  = 0;
  localparam int HDR_ID_W    = DATA_W_DEF;
  localparam int LEN_LSB     = 0;
  localparam int LEN_W       = DATA_W_DEF;

  localparam int TEST_PAT  = 0;
  localparam int FILL_RECT = 1;
  localparam int DRAW_LINE = 2;
  localparam int BLIT      = 3;
  localparam int CLEAR     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_dispatcher_if.sv
// Byte stream from the I2C receiver and the one-hot broadcast bus to the
// engines; master is the dispatcher side, slave is the environment side.
interface cmd_dispatcher_if
  import cmd_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int DATA_W      = DATA_W_DEF
);

  logic                   i2c_rts;
  logic                   i2c_rtr;
  logic [DATA_W-1:0]      i2c_in_data;
  logic [NUM_ENGINES-1:0] engine_out_rts;
  logic [NUM_ENGINES-1:0] engine_in_rtr;
  logic [DATA_W-1:0]      bcast_out_data;

  modport master (
    input  i2c_rts,
    input  i2c_in_data,
    input  engine_in_rtr,
    output i2c_rtr,
    output engine_out_rts,
    output bcast_out_data
  );

  modport slave (
    output i2c_rts,
    output i2c_in_data,
    output engine_in_rtr,
    input  i2c_rtr,
    input  engine_out_rts,
    input  bcast_out_data
  );

endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with registered storage; the head entry is
// visible combinationally so the consumer can peek before popping.
module cmd_fifo
  import cmd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
  input  logic              clk,
  input  logic              rst_,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Packet parser and payload router: pops header, length and payload from
// the input FIFO and streams the payload to one engine at a time.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int ERR_CNT_W   = ERR_CNT_W_DEF
)(
  input  logic                 clk,
  input  logic                 rst_,
  cmd_dispatcher_if.master     bus,
  input  logic                 flush,
  output logic                 busy,
  output logic                 err_bad_cmd,
  output logic [ERR_CNT_W-1:0] bad_cmd_count
);

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  state_t                 state, state_nxt;
  logic [DATA_W-1:0]      cur_id, cur_id_nxt;
  logic                   valid, valid_nxt;
  logic [DATA_W-1:0]      remaining, remaining_nxt;
  logic                   fsm_pop;
  logic                   bad_hdr;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_W-1:0]      fifo_head;
  logic [NUM_ENGINES-1:0] sel_mask;
  logic                   sel_rtr;

  assign fifo_push = bus.i2c_rts && !fifo_full && !flush;
  assign fifo_pop  = fsm_pop && !flush;

  cmd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .flush (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.i2c_in_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Decode of the latched engine ID; only meaningful once the header was valid.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      sel_mask[i] = (cur_id == DATA_W'(i));
    end
  end

  assign sel_rtr            = |(bus.engine_in_rtr & sel_mask);
  assign bus.i2c_rtr        = !fifo_full;
  assign bus.bcast_out_data = fifo_head;
  assign bus.engine_out_rts = (state == ST_PAYLOAD && !fifo_empty) ? sel_mask : '0;
  assign busy               = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_nxt     = state;
    cur_id_nxt    = cur_id;
    valid_nxt     = valid;
    remaining_nxt = remaining;
    fsm_pop       = 1'b0;
    bad_hdr       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fsm_pop    = 1'b1;
          cur_id_nxt = fifo_head;
          state_nxt  = ST_LEN;
          if (fifo_head < DATA_W'(NUM_ENGINES)) begin
            valid_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b0;
            bad_hdr   = 1'b1;
          end
        end
      end
      ST_LEN: begin
        if (!fifo_empty) begin
          fsm_pop       = 1'b1;
          remaining_nxt = fifo_head;
          if (fifo_head == '0)  state_nxt = ST_IDLE;
          else if (valid)       state_nxt = ST_PAYLOAD;
          else                  state_nxt = ST_DISCARD;
        end
      end
      ST_PAYLOAD: begin
        if (!fifo_empty && sel_rtr) begin
          fsm_pop       = 1'b1;
          remaining_nxt = remaining - DATA_W'(1);
          if (remaining == DATA_W'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (!fifo_empty) begin
          fsm_pop       = 1'b1;
          remaining_nxt = remaining - DATA_W'(1);
          if (remaining == DATA_W'(1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flush aborts the packet in flight but keeps the error history.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state         <= ST_IDLE;
      cur_id        <= '0;
      valid         <= 1'b0;
      remaining     <= '0;
      err_bad_cmd   <= 1'b0;
      bad_cmd_count <= '0;
    end else if (flush) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      err_bad_cmd   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cur_id        <= cur_id_nxt;
      valid         <= valid_nxt;
      remaining     <= remaining_nxt;
      err_bad_cmd   <= bad_hdr;
      if (bad_hdr) bad_cmd_count <= sat_inc(bad_cmd_count);
    end
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed bench for cmd_dispatcher: byte-stream stimulus with
// hand-computed engine transfers, stalls, bad headers, flush and reset.
module tb_cmd_dispatcher;
  import cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       flush = 1'b0;
  logic       busy;
  logic       err_bad_cmd;
  logic [7:0] bad_cmd_count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  tx_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [4:0]  rts_seen;

  cmd_dispatcher_if #(.NUM_ENGINES(5), .DATA_W(8)) bus ();

  cmd_dispatcher #(
    .NUM_ENGINES (5),
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .ERR_CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rst_          (rst_),
    .bus           (bus),
    .flush         (flush),
    .busy          (busy),
    .err_bad_cmd   (err_bad_cmd),
    .bad_cmd_count (bad_cmd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 31;
  endfunction

  task automatic drive_tx();
    bus.i2c_rts     = (tx_q.size() != 0);
    bus.i2c_in_data = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  endtask

  // One clock: record transfers seen before the edge, then advance the byte source.
  task automatic cyc();
    logic acc;
    acc = bus.i2c_rts && bus.i2c_rtr;
    if ((bus.engine_out_rts & bus.engine_in_rtr) != 5'b0)
      got_q.push_back({8'(oh_idx(bus.engine_out_rts)), bus.bcast_out_data});
    rts_seen = rts_seen | bus.engine_out_rts;
    @(posedge clk);
    #1;
    if (acc && tx_q.size() != 0) void'(tx_q.pop_front());
    drive_tx();
  endtask

  task automatic run_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || busy) && n < bound) begin
      cyc();
      n++;
    end
    check({tag, "_done"}, 32'(n < bound), 32'd1);
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, (i < got_q.size()) ? {16'h0, got_q[i]} : 32'hDEAD_BEEF, {16'h0, exp_q[i]});
    end
  endtask

  task automatic start_pkt();
    got_q.delete();
    exp_q.delete();
    rts_seen = 5'b0;
    drive_tx();
  endtask

  initial begin
    bus.i2c_rts       = 1'b0;
    bus.i2c_in_data   = 8'h00;
    bus.engine_in_rtr = 5'b11111;
    rts_seen          = 5'b0;
    repeat (3) @(posedge clk);
    #2 rst_ = 1'b1;
    @(posedge clk);
    #1;

    check("rst_rtr",   32'(bus.i2c_rtr),        32'd1);
    check("rst_rts",   32'(bus.engine_out_rts), 32'd0);
    check("rst_busy",  32'(busy),               32'd0);
    check("rst_err",   32'(err_bad_cmd),        32'd0);
    check("rst_count", 32'(bad_cmd_count),      32'd0);

    // Basic packet to FILL_RECT
    tx_q = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    start_pkt();
    repeat (3) cyc();
    check("t1_rts0",  32'(bus.engine_out_rts), 32'h02);
    check("t1_dat0",  32'(bus.bcast_out_data), 32'hAA);
    cyc();
    check("t1_rts1",  32'(bus.engine_out_rts), 32'h02);
    check("t1_dat1",  32'(bus.bcast_out_data), 32'hBB);
    cyc();
    check("t1_rts2",  32'(bus.engine_out_rts), 32'h02);
    check("t1_dat2",  32'(bus.bcast_out_data), 32'hCC);
    cyc();
    check("t1_rts_end",  32'(bus.engine_out_rts), 32'd0);
    check("t1_busy_end", 32'(busy),               32'd0);
    exp_q = '{{8'(FILL_RECT), 8'hAA}, {8'(FILL_RECT), 8'hBB}, {8'(FILL_RECT), 8'hCC}};
    check_got("t1_xfer");

    // Back-pressure from engine 1 with the next packet queued behind
    tx_q = '{8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h01, 8'h55};
    start_pkt();
    repeat (4) cyc();
    bus.engine_in_rtr = 5'b11101;
    for (int k = 0; k < 4; k++) begin
      check("t2_stall_rts", 32'(bus.engine_out_rts), 32'h02);
      check("t2_stall_dat", 32'(bus.bcast_out_data), 32'hBB);
      cyc();
    end
    check("t2_full_rtr", 32'(bus.i2c_rtr),        32'd0);
    check("t2_hold_rts", 32'(bus.engine_out_rts), 32'h02);
    check("t2_hold_dat", 32'(bus.bcast_out_data), 32'hBB);
    bus.engine_in_rtr = 5'b11111;
    run_idle("t2", 60);
    exp_q = '{{8'd1, 8'hAA}, {8'd1, 8'hBB}, {8'd1, 8'hCC}, {8'(DRAW_LINE), 8'h55}};
    check_got("t2_xfer");

    // Unknown engine 7 is discarded and flagged
    tx_q = '{8'h07, 8'h02, 8'h11, 8'h22, 8'h02, 8'h01, 8'h55};
    start_pkt();
    repeat (2) cyc();
    check("t3_err_pulse", 32'(err_bad_cmd),   32'd1);
    check("t3_count",     32'(bad_cmd_count), 32'd1);
    cyc();
    check("t3_err_clear", 32'(err_bad_cmd),   32'd0);
    run_idle("t3", 60);
    exp_q = '{{8'd2, 8'h55}};
    check_got("t3_xfer");
    check("t3_rts_seen", 32'(rts_seen), 32'h04);

    // Zero-length packet for BLIT, then one byte for CLEAR
    tx_q = '{8'h03, 8'h00, 8'h04, 8'h01, 8'h66};
    start_pkt();
    run_idle("t4", 60);
    exp_q = '{{8'(CLEAR), 8'h66}};
    check_got("t4_xfer");
    check("t4_rts_seen", 32'(rts_seen), 32'h10);

    // Flush with payload pending; a write in the flush cycle is dropped
    bus.engine_in_rtr = 5'b11110;
    tx_q = '{8'h00, 8'h05, 8'h01, 8'h02};
    start_pkt();
    repeat (4) cyc();
    check("t5_pre_busy", 32'(busy),               32'd1);
    check("t5_pre_rts",  32'(bus.engine_out_rts), 32'h01);
    tx_q.push_back(8'h99);
    drive_tx();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t5_post_busy", 32'(busy),               32'd0);
    check("t5_post_rts",  32'(bus.engine_out_rts), 32'd0);
    check("t5_post_rtr",  32'(bus.i2c_rtr),        32'd1);
    check("t5_keep_count", 32'(bad_cmd_count),     32'd1);
    bus.engine_in_rtr = 5'b11111;
    tx_q = '{8'h02, 8'h01, 8'h77};
    start_pkt();
    run_idle("t5", 60);
    exp_q = '{{8'd2, 8'h77}};
    check_got("t5_xfer");

    // 300 bad headers push the counter into saturation
    tx_q.delete();
    for (int i = 0; i < 300; i++) begin
      tx_q.push_back(8'hFF);
      tx_q.push_back(8'h00);
    end
    start_pkt();
    run_idle("t6", 2000);
    check("t6_sat_count", 32'(bad_cmd_count),   32'hFF);
    check("t6_rts_seen",  32'(rts_seen),        32'd0);

    // Asynchronous reset while engine 1 is stalled mid-payload
    bus.engine_in_rtr = 5'b11101;
    tx_q = '{8'h01, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    start_pkt();
    repeat (4) cyc();
    check("t7_pre_rts", 32'(bus.engine_out_rts), 32'h02);
    #2;
    rst_ = 1'b0;
    tx_q.delete();
    drive_tx();
    #1;
    check("t7_rst_rts",   32'(bus.engine_out_rts), 32'd0);
    check("t7_rst_busy",  32'(busy),               32'd0);
    check("t7_rst_rtr",   32'(bus.i2c_rtr),        32'd1);
    check("t7_rst_err",   32'(err_bad_cmd),        32'd0);
    check("t7_rst_count", 32'(bad_cmd_count),      32'd0);
    #2 rst_ = 1'b1;
    @(posedge clk);
    #1;
    check("t7_after_busy", 32'(busy),               32'd0);
    check("t7_after_rts",  32'(bus.engine_out_rts), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
